instr_encoder: RTL and testbench



---
 rtl/instr_encoder.sv | 178 +++++++++++++++++
 tb/tb_instr_encoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Purpose  : Packs decoded RV32I fields into machine words, buffers them in a
//            FIFO and streams them out with sequential byte addresses.
//            Optional macro INSTR_ENCODER_RANGE_CHECK_EN enables immediate
//            range checking (err_range).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W-1:0] words_out,
  output logic              err_illegal,
  output logic              err_range
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_SW  = 3'd1;
  localparam logic [2:0] OP_R   = 3'd2;
  localparam logic [2:0] OP_BEQ = 3'd3;
  localparam logic [2:0] OP_I   = 3'd4;
  localparam logic [2:0] OP_JAL = 3'd5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] words_q;
  logic              illegal_q;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        range_ok;
  logic        accept;
  logic        push;
  logic        pop;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_op)
      OP_LW:   enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD};
      OP_SW:   enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STORE};
      OP_R:    enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OPC_REG};
      OP_BEQ:  enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                           in_imm[4:1], in_imm[11], OPC_BRANCH};
      OP_I:    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_IMM};
      OP_JAL:  enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                           in_rd, OPC_JAL};
      default: enc_legal = 1'b0;
    endcase
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic fits12;
  logic fits13;
  logic fits21;
  logic err_range_q;

  // A value fits N signed bits when every bit from N-1 upward matches the sign.
  assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    range_ok = 1'b1;
    case (in_op)
      OP_LW, OP_SW, OP_I: range_ok = fits12;
      OP_BEQ:             range_ok = fits13 & ~in_imm[0];
      OP_JAL:             range_ok = fits21 & ~in_imm[0];
      default:            range_ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_range_q <= 1'b0;
    end else if (accept && enc_legal && !range_ok) begin
      err_range_q <= 1'b1;
    end
  end

  assign err_range = err_range_q;
`else
  logic unused_imm_bits;

  assign range_ok        = 1'b1;
  assign err_range       = 1'b0;
  assign unused_imm_bits = ^{in_imm[31:21], in_imm[0]};
`endif

  // restart (and reset) take priority over any handshake in the same cycle.
  assign accept = in_valid && ready_q && !restart && !reset;
  assign push   = accept && enc_legal && range_ok;
  assign pop    = out_valid && out_ready && !restart && !reset;

  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
      addr_q  <= BASE_ADDR;
      words_q <= '0;
    end else begin
      count   <= count_next;
      ready_q <= (count_next != FULL_CNT);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        addr_q  <= addr_q + ADDR_W'(4);
        words_q <= words_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (accept && !enc_legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = (count != '0);
  assign out_instr   = out_valid ? mem[rd_ptr] : 32'h0;
  assign out_addr    = addr_q;
  assign words_out   = words_q;
  assign err_illegal = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Directed self-checking bench for instr_encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        restart;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [31:0] words_out;
  logic        err_illegal;
  logic        err_range;

  int errors = 0;
  int checks = 0;

  instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .words_out(words_out),
    .err_illegal(err_illegal), .err_range(err_range)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a bundle, wait (bounded) for in_ready, complete the handshake.
  task automatic send(input logic [2:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm);
    int n;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for the head word, compare it, then pop it.
  task automatic expect_word(input string name, input logic [31:0] exp_i,
                             input logic [31:0] exp_a);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_instr !== exp_i || out_addr !== exp_a) begin
      errors++;
      $display("FAIL %s: valid=%b instr=%h addr=%h required valid=1 instr=%h addr=%h",
               name, out_valid, out_instr, out_addr, exp_i, exp_a);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_restart;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if (out_addr !== 32'h0 || words_out !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_state: addr=%h words=%0d valid=%b ready=%b required 0 0 0 1",
               out_addr, words_out, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== 32'h0 ||
        words_out !== 32'h0 || err_illegal !== 1'b0 || err_range !== 1'b0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b instr=%h addr=%h words=%0d ill=%b rng=%b ready=%b required 0 0 0 0 0 0 1",
               out_valid, out_instr, out_addr, words_out, err_illegal, err_range, in_ready);
    end
  endtask

  task automatic test_lw;
    out_ready = 1'b1;
    send(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 32'd8);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00812283 || out_addr !== 32'h0) begin
      errors++;
      $display("FAIL lw_word: valid=%b instr=%h addr=%h required 1 00812283 00000000",
               out_valid, out_instr, out_addr);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || words_out !== 32'd1 || out_addr !== 32'h4) begin
      errors++;
      $display("FAIL lw_pop: valid=%b words=%0d addr=%h required 0 1 00000004",
               out_valid, words_out, out_addr);
    end
  endtask

  task automatic test_rtype_sw;
    do_restart();
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    send(3'd1, 5'd0, 5'd2, 5'd5, 3'd0, 7'd0, 32'd12);
    // addi x6,x7,-1 with junk in funct7/rs2 that must be ignored
    send(3'd4, 5'd6, 5'd7, 5'd31, 3'd0, 7'h7F, 32'hFFFF_FFFF);
    expect_word("add_word", 32'h002081B3, 32'h0);
    expect_word("sw_word", 32'h00512623, 32'h4);
    expect_word("addi_word", 32'hFFF38313, 32'h8);
  endtask

  task automatic test_branch_jal;
    do_restart();
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8);
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16);
    expect_word("beq_word", 32'hFE208CE3, 32'h0);
    expect_word("jal_word", 32'h010000EF, 32'h4);
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_w [5];
    int k;
    int n;
    logic acc;
    exp_w[0] = 32'h00000093; exp_w[1] = 32'h00100093; exp_w[2] = 32'h00200093;
    exp_w[3] = 32'h00300093; exp_w[4] = 32'h00400093;
    do_restart();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
    end
    checks++;
    if (in_ready !== 1'b0 || out_instr !== exp_w[0]) begin
      errors++;
      $display("FAIL full_ready: ready=%b instr=%h required 0 %h", in_ready, out_instr, exp_w[0]);
    end
    in_imm = 32'd4;
    in_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== exp_w[0]) begin
      errors++;
      $display("FAIL full_hold: ready=%b valid=%b instr=%h required 0 1 %h",
               in_ready, out_valid, out_instr, exp_w[0]);
    end
    out_ready = 1'b1;
    k = 0;
    n = 0;
    while (k < 5 && n < 60) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        checks++;
        if (out_instr !== exp_w[k] || out_addr !== 32'(k * 4)) begin
          errors++;
          $display("FAIL drain_%0d: instr=%h addr=%h required %h %h",
                   k, out_instr, out_addr, exp_w[k], 32'(k * 4));
        end
        k++;
      end
      tick();
      if (acc) in_valid = 1'b0;
      n++;
    end
    out_ready = 1'b0;
    checks++;
    if (k !== 5 || words_out !== 32'd5 || in_valid !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_done: popped=%0d words=%0d pending=%b valid=%b required 5 5 0 0",
               k, words_out, in_valid, out_valid);
    end
  endtask

  task automatic test_illegal_restart;
    do_restart();
    send(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 32'd8);
    expect_word("pre_illegal_word", 32'h00812283, 32'h0);
    send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    tick();
    checks++;
    if (err_illegal !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_flag: err_illegal=%b valid=%b required 1 0", err_illegal, out_valid);
    end
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    expect_word("post_illegal_word", 32'h002081B3, 32'h4);
    do_restart();
    checks++;
    if (err_illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky: err_illegal=%b required 1", err_illegal);
    end
  endtask

  task automatic test_reset_midstream;
    send(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 32'd8);
    send(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 32'd8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== 32'h0 ||
        words_out !== 32'h0 || err_illegal !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midstream_reset: valid=%b instr=%h addr=%h words=%0d ill=%b ready=%b required 0 0 0 0 0 1",
               out_valid, out_instr, out_addr, words_out, err_illegal, in_ready);
    end
  endtask

  task automatic test_range;
    send(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick();
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    checks++;
    if (err_range !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL range_flag: err_range=%b valid=%b required 1 0", err_range, out_valid);
    end
    send(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
    expect_word("range_min_ok", 32'h80012283, 32'h0);
`else
    checks++;
    if (err_range !== 1'b0) begin
      errors++;
      $display("FAIL range_off_flag: err_range=%b required 0", err_range);
    end
    expect_word("range_trunc_word", 32'h80012283, 32'h0);
`endif
  endtask

  initial begin
    reset = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    test_reset();
    test_lw();
    test_rtype_sw();
    test_branch_jal();
    test_backpressure();
    test_illegal_restart();
    test_reset_midstream();
    test_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
